// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART receive path: 16x oversampled deserializer with one-entry holding register
module uart_receiver #(
  parameter int SAMPLE_PT   = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic [7:0] lcr,
  input  logic       enable,
  input  logic       srx_pad_i,
  input  logic       rx_reset,
  input  logic       rx_pop,
  input  logic       rx_lsr_mask,
  output logic [7:0] rx_data,
  output logic       rx_pe,
  output logic       rx_fe,
  output logic       rx_bi,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic [2:0] rx_state,
  output logic       rx_idle
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_PUSH   = 3'd5
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_tick;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_pbit;
  logic                   r_pe;
  logic                   r_fe;
  logic                   r_bi;
  logic                   r_line_ok;
  logic [7:0]             r_rx_data;
  logic                   r_rx_pe;
  logic                   r_rx_fe;
  logic                   r_rx_bi;
  logic                   r_rx_valid;
  logic                   r_rx_overrun;

  logic w_srx;
  logic w_rst;
  logic w_sample;
  logic w_last_bit;
  logic w_par_exp;
  logic w_push;
  logic w_overflow;
  logic w_unused;

  assign w_srx      = r_sync[SYNC_STAGES-1];
  assign w_rst      = wb_rst_i | rx_reset;
  assign w_sample   = (r_tick == 4'(SAMPLE_PT));
  assign w_last_bit = (r_bit_cnt == (3'd4 + {1'b0, lcr[1:0]}));
  // Stick parity forces the bit to ~EP; otherwise EP selects even vs odd.
  assign w_par_exp  = lcr[5] ? ~lcr[4] : (lcr[4] ? ^r_shift : ~(^r_shift));
  assign w_push     = (r_state == S_PUSH);
  assign w_overflow = w_push & r_rx_valid & ~rx_pop;
  assign w_unused   = &{1'b0, lcr[7:6]};

  // Metastability synchroniser; presets to idle-high so reset never fakes a start bit
  always_ff @(posedge clk) begin
    if (wb_rst_i) r_sync <= '1;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], srx_pad_i};
  end

  // Frame decoder; advances on baud ticks except the push state, which always lasts one clk
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state   <= S_IDLE;
      r_tick    <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_pbit    <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_bi      <= 1'b0;
      r_line_ok <= 1'b0;
    end else if (r_state == S_PUSH) begin
      r_state <= S_IDLE;
    end else if (enable) begin
      r_tick <= r_tick + 4'd1;
      case (r_state)
        S_IDLE: begin
          if (w_srx) begin
            r_line_ok <= 1'b1;
          end else if (r_line_ok) begin
            r_tick  <= 4'd0;
            r_shift <= 8'd0;
            r_pbit  <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
            r_bi    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_sample) begin
            if (!w_srx) begin
              r_bit_cnt <= 3'd0;
              r_state   <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_sample) begin
            r_shift[r_bit_cnt] <= w_srx;
            if (w_last_bit) r_state <= lcr[3] ? S_PARITY : S_STOP;
            else            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_pbit  <= w_srx;
            r_pe    <= w_srx ^ w_par_exp;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_sample) begin
            r_fe <= ~w_srx;
            // r_pbit stays 0 when parity is disabled, so it only vetoes a break when sampled high
            r_bi <= (r_shift == 8'd0) & ~r_pbit & ~w_srx;
            if (!w_srx) r_line_ok <= 1'b0;
            r_state <= S_PUSH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register with valid/pop handshake and sticky overrun; runs every clk
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_rx_data    <= 8'd0;
      r_rx_pe      <= 1'b0;
      r_rx_fe      <= 1'b0;
      r_rx_bi      <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else begin
      if (w_push && (!r_rx_valid || rx_pop)) begin
        r_rx_data  <= r_shift;
        r_rx_pe    <= r_pe;
        r_rx_fe    <= r_fe;
        r_rx_bi    <= r_bi;
        r_rx_valid <= 1'b1;
      end else if (!w_push && rx_pop) begin
        r_rx_valid <= 1'b0;
      end
      r_rx_overrun <= w_overflow | (r_rx_overrun & ~rx_lsr_mask);
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_pe      = r_rx_pe;
  assign rx_fe      = r_rx_fe;
  assign rx_bi      = r_rx_bi;
  assign rx_valid   = r_rx_valid;
  assign rx_overrun = r_rx_overrun;
  assign rx_state   = r_state;
  assign rx_idle    = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  logic       clk;
  logic       wb_rst_i;
  logic [7:0] lcr;
  logic       enable;
  logic       srx_pad_i;
  logic       rx_reset;
  logic       rx_pop;
  logic       rx_lsr_mask;
  logic [7:0] rx_data;
  logic       rx_pe;
  logic       rx_fe;
  logic       rx_bi;
  logic       rx_valid;
  logic       rx_overrun;
  logic [2:0] rx_state;
  logic       rx_idle;

  int errors = 0;
  int checks = 0;

  uart_receiver #(.SAMPLE_PT(7), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .wb_rst_i   (wb_rst_i),
    .lcr        (lcr),
    .enable     (enable),
    .srx_pad_i  (srx_pad_i),
    .rx_reset   (rx_reset),
    .rx_pop     (rx_pop),
    .rx_lsr_mask(rx_lsr_mask),
    .rx_data    (rx_data),
    .rx_pe      (rx_pe),
    .rx_fe      (rx_fe),
    .rx_bi      (rx_bi),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun),
    .rx_state   (rx_state),
    .rx_idle    (rx_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 16x tick every second clk, one clk wide: one bit period is 32 clks
  initial begin
    enable = 1'b0;
    forever begin
      @(negedge clk);
      enable = ~enable;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    srx_pad_i = v;
    repeat (32) @(negedge clk);
  endtask

  task automatic pop_char();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen, input logic pb,
                            input bit pop_in_push, output bit found,
                            output logic v_at, output logic v_after);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pb);
    srx_pad_i = 1'b1;
    found = 1'b0;
    v_at = 1'b0;
    for (int c = 0; c < 48 && !found; c++) begin
      @(negedge clk);
      if (rx_state === 3'd5) begin
        found = 1'b1;
        v_at  = rx_valid;
        if (pop_in_push) rx_pop = 1'b1;
      end
    end
    @(negedge clk);
    rx_pop  = 1'b0;
    v_after = rx_valid;
    repeat (40) @(negedge clk);
  endtask

  bit   found;
  logic v_at;
  logic v_after;

  initial begin
    wb_rst_i    = 1'b1;
    lcr         = 8'h03;
    srx_pad_i   = 1'b1;
    rx_reset    = 1'b0;
    rx_pop      = 1'b0;
    rx_lsr_mask = 1'b0;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;

    chk("rst_state", rx_state, 3'd0);
    chk("rst_idle", rx_idle, 1'b1);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_flags", {rx_pe, rx_fe, rx_bi, rx_overrun}, 4'b0000);
    repeat (64) @(negedge clk);

    // 8N1 0xA5 with push latency
    lcr = 8'h03;
    send_frame(8'hA5, 8, 0, 1'b0, 0, found, v_at, v_after);
    chk("8n1_push_seen", found, 1'b1);
    chk("8n1_valid_in_push", v_at, 1'b0);
    chk("8n1_valid_after_push", v_after, 1'b1);
    chk("8n1_data", rx_data, 8'hA5);
    chk("8n1_flags", {rx_pe, rx_fe, rx_bi}, 3'b000);
    pop_char();
    chk("pop_valid", rx_valid, 1'b0);
    chk("pop_data_hold", rx_data, 8'hA5);

    // 7E1: 0x41 has even ones, so the correct parity bit is 0
    lcr = 8'h1A;
    send_frame(8'h41, 7, 1, 1'b1, 0, found, v_at, v_after);
    chk("7e1_bad_data", rx_data, 8'h41);
    chk("7e1_bad_pe", rx_pe, 1'b1);
    pop_char();
    send_frame(8'h41, 7, 1, 1'b0, 0, found, v_at, v_after);
    chk("7e1_good_data", rx_data, 8'h41);
    chk("7e1_good_pe", rx_pe, 1'b0);
    pop_char();

    // 5N1 and break
    lcr = 8'h00;
    send_frame(8'h13, 5, 0, 1'b0, 0, found, v_at, v_after);
    chk("5n1_data", rx_data, 8'h13);
    pop_char();
    srx_pad_i = 1'b0;
    repeat (640) @(negedge clk);
    chk("brk_valid", rx_valid, 1'b1);
    chk("brk_data", rx_data, 8'h00);
    chk("brk_flags", {rx_pe, rx_fe, rx_bi}, 3'b011);
    chk("brk_wait_idle", rx_state, 3'd0);
    srx_pad_i = 1'b1;
    repeat (64) @(negedge clk);
    chk("brk_single_char", rx_overrun, 1'b0);
    pop_char();
    chk("brk_pop", rx_valid, 1'b0);

    // start glitch of 4 ticks
    lcr = 8'h03;
    srx_pad_i = 1'b0;
    repeat (5) @(negedge clk);
    chk("glitch_in_start", rx_state, 3'd1);
    repeat (3) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (64) @(negedge clk);
    chk("glitch_state", rx_state, 3'd0);
    chk("glitch_valid", rx_valid, 1'b0);

    // overrun
    send_frame(8'h11, 8, 0, 1'b0, 0, found, v_at, v_after);
    send_frame(8'h22, 8, 0, 1'b0, 0, found, v_at, v_after);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_set", rx_overrun, 1'b1);
    chk("ovr_valid", rx_valid, 1'b1);
    rx_lsr_mask = 1'b1;
    @(negedge clk);
    rx_lsr_mask = 1'b0;
    chk("ovr_clear", rx_overrun, 1'b0);
    send_frame(8'h33, 8, 0, 1'b0, 1, found, v_at, v_after);
    chk("poppush_seen", found, 1'b1);
    chk("popush_data", rx_data, 8'h33);
    chk("popush_valid", rx_valid, 1'b1);
    chk("popush_no_ovr", rx_overrun, 1'b0);

    // wb_rst_i mid data bit (0x5A: start, b0=0, b1=1, b2=0)
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    srx_pad_i = 1'b0;
    repeat (16) @(negedge clk);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    chk("hrst_state", rx_state, 3'd0);
    chk("hrst_valid", rx_valid, 1'b0);
    chk("hrst_data", rx_data, 8'h00);
    srx_pad_i = 1'b1;
    repeat (64) @(negedge clk);
    send_frame(8'h5A, 8, 0, 1'b0, 0, found, v_at, v_after);
    chk("hrst_next_data", rx_data, 8'h5A);
    chk("hrst_next_valid", rx_valid, 1'b1);

    // rx_reset mid data bit, holding register still full
    drive_bit(1'b0);
    drive_bit(1'b0);
    srx_pad_i = 1'b1;
    repeat (16) @(negedge clk);
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    chk("srst_state", rx_state, 3'd0);
    chk("srst_valid", rx_valid, 1'b0);
    repeat (64) @(negedge clk);
    send_frame(8'h5A, 8, 0, 1'b0, 0, found, v_at, v_after);
    chk("srst_next_data", rx_data, 8'h5A);
    chk("srst_next_flags", {rx_valid, rx_pe, rx_fe, rx_bi, rx_overrun}, 5'b10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receive path of the UART, mirroring the transmit serializer.
- Oversamples srx_pad_i on the shared 16x baud enable tick and decodes frames of 5-8 data bits, optional parity, and stop bit(s) per lcr.
- Delivers each character plus its PE/FE/BI status through a one-entry holding register with valid/pop handshake.
- Sits between the pad and the receive FIFO/LSR logic.

Parameters:
- SAMPLE_PT, 7, enable-tick index (0-15) within each bit period at which the line is sampled.
- SYNC_STAGES, 2, number of input synchroniser flops on srx_pad_i (minimum 2).

Ports:
- clk  input  1  system clock.
- wb_rst_i  input  1  reset; one clock, reset is synchronous and active-high.
- lcr  input  8  line control: [1:0] bits, [2] stop bits, [3] PE, [4] EP, [5] SP; [7:6] ignored.
- enable  input  1  16x baud tick, one clk wide.
- srx_pad_i  input  1  serial input; idle high.
- rx_reset  input  1  synchronous soft flush.
- rx_pop  input  1  consumer takes the held character.
- rx_lsr_mask  input  1  LSR read pulse; clears overrun.
- rx_data  output  8  received character, right-aligned, unused upper bits 0.
- rx_pe  output  1  parity error for rx_data.
- rx_fe  output  1  framing error for rx_data.
- rx_bi  output  1  break indication for rx_data.
- rx_valid  output  1  holding register full.
- rx_overrun  output  1  sticky overrun.
- rx_state  output  3  current FSM state, for debug/LSR.
- rx_idle  output  1  FSM in s_idle.

Behaviour:
- Reset (wb_rst_i=1, or rx_reset=1):
  - FSM enters s_idle; tick counter, bit counter and shift register clear to 0.
  - rx_data=0, rx_pe=rx_fe=rx_bi=0, rx_valid=0, rx_overrun=0, rx_idle=1.
  - Synchroniser flops preset to 1 on wb_rst_i only.
  - Reset is sampled at the clk edge and overrides every other input, including mid-frame; the partial frame is discarded.
- Synchroniser: srx_pad_i passes through SYNC_STAGES flops every clk regardless of enable. The synchronised value is srx.
- Clock gating: the FSM and counters advance only on cycles with enable=1. With enable=0 they hold; the pop/overrun logic still runs every clk.
- Bit timing: 4-bit tick counter, wraps 15->0. Data is sampled when tick==SAMPLE_PT, giving exactly 16 ticks between consecutive samples.
- FSM states (rx_state encoding):
  - s_idle=0: when srx==0 and line_ok=1, set tick=0 and go to s_start. line_ok sets whenever srx==1 is seen in s_idle.
  - s_start=1: at tick==SAMPLE_PT, if srx==0 go to s_data with bit_cnt=0; if srx==1 (glitch) go to s_idle with no push and no flags.
  - s_data=2: at each sample, shift srx into bit position bit_cnt (LSB first). After the sample for bit_cnt==4+lcr[1:0], go to s_parity if lcr[3]=1, else s_stop.
  - s_parity=3: sample parity bit p. Expected value:
    - SP=0, EP=1: even, p == XOR(data).
    - SP=0, EP=0: odd, p == ~XOR(data).
    - SP=1, EP=0: p == 1.
    - SP=1, EP=1: p == 0.
    - pe is the mismatch. Go to s_stop.
  - s_stop=4: sample the first stop bit only; lcr[2] never lengthens reception. fe = ~srx. bi = 1 when data==0, p==0 (if parity enabled) and stop==0. If fe=1, clear line_ok. Go to s_push.
  - s_push=5: a single clk that ignores enable. Perform the push, then go to s_idle.
  - Codes 6/7 go to s_idle.
- Push: if rx_valid=0, or rx_pop=1 in the same cycle, load rx_data/pe/fe/bi and set rx_valid=1. Otherwise discard the character and set rx_overrun=1.
- Latency: rx_valid rises on the clk edge after the s_push cycle, i.e. 2 clks after the stop-sample tick.
- Pop: with rx_pop=1 and no push, rx_valid clears on the next edge and the flags hold their value. rx_pop with rx_valid=0 is ignored.
- Overrun: sticky. Cleared by rx_lsr_mask, rx_reset or wb_rst_i. A set and a clear in the same cycle leave it set.
- lcr is sampled live; changing it mid-frame is undefined but must not lock up the FSM.

Test Plan:
- 8N1 (lcr=0x03), send 0xA5 at 16 ticks/bit -> rx_valid=1, rx_data=0xA5, pe=fe=bi=0; 2 clks after the stop sample.
- 7E1 (lcr=0x1A), send 0x41 with parity bit 1 -> rx_data=0x41, rx_pe=1; repeat with parity 0 -> rx_pe=0.
- 5N1 (lcr=0x00), send 0x13 -> rx_data=0x13. Then hold the line low for 2 frames -> one character with rx_data=0x00, rx_bi=1, rx_fe=1, and no second start until the line returns high.
- Start glitch: line low for 4 ticks, then high -> no push, FSM back to s_idle, rx_valid stays 0.
- Overrun: receive 0x11 then 0x22 without pop -> rx_data=0x11, rx_overrun=1. rx_lsr_mask pulse -> rx_overrun=0. rx_pop asserted in the push cycle of 0x33 -> rx_data=0x33, rx_valid=1, no overrun.
- wb_rst_i, then separately rx_reset, asserted mid-data-bit -> next clk rx_state=0, rx_valid=0. The following clean frame 0x5A is received correctly.
